mips_dmem_responder: RTL

//  Word-addressed data-memory target for the MIPS32 pipeline's LW/SW traffic once memory moves off-core.

---
 rtl/mips_mem_pkg.sv | 19 +
 rtl/dmem_sram_1rw.sv | 23 ++
 rtl/mips_dmem_responder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS32 off-core data-memory responder.
package mips_mem_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned DEF_DEPTH   = 1024;
  localparam int unsigned DEF_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] rdata;
    logic              err;
  } rsp_t;

endpackage

// File: rtl/dmem_sram_1rw.sv
// Single-port synchronous RAM: write on posedge, read-first registered read data.
module dmem_sram_1rw #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mips_dmem_responder.sv
// Word-addressed LW/SW data-memory target with programmable wait states,
// out-of-range detection and saturating access counters.
module mips_dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned LATENCY = DEF_LATENCY,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LAT_W = 4;

  state_t            state;
  logic [LAT_W-1:0]  wait_cnt;
  logic              we_q;
  logic              oor_q;
  logic [AW-1:0]     addr_q;
  logic              load_q;
  logic              err_q;

  logic              accept_c;
  logic              in_range_c;
  logic              sram_we_c;
  logic [AW-1:0]     sram_addr_c;
  logic [WORD_W-1:0] sram_rdata;
  rsp_t              rsp_c;

  // Full 32-bit compare so high address bits can never alias into the array.
  assign in_range_c  = (req_addr < WORD_W'(DEPTH));
  assign accept_c    = (state == IDLE) && req_ready && req_valid;
  assign sram_we_c   = rst_n && accept_c && req_we && in_range_c;
  // The array sees the live request address in IDLE (store commit, zero-latency read)
  // and the captured address afterwards, so the read lands on the RESP edge and stays put.
  assign sram_addr_c = (state == IDLE) ? req_addr[AW-1:0] : addr_q;

  dmem_sram_1rw #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W),
    .AW    (AW)
  ) u_sram (
    .clk   (clk),
    .we    (sram_we_c),
    .addr  (sram_addr_c),
    .wdata (req_wdata),
    .rdata (sram_rdata)
  );

  // Read data is the RAM's output register, qualified by a registered load flag.
  assign rsp_c.rdata          = load_q ? sram_rdata : '0;
  assign rsp_c.err            = err_q;
  assign {rsp_rdata, rsp_err} = rsp_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      err_q     <= 1'b0;
      load_q    <= 1'b0;
      wait_cnt  <= '0;
      we_q      <= 1'b0;
      oor_q     <= 1'b0;
      addr_q    <= '0;
      rd_count  <= '0;
      wr_count  <= '0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            oor_q     <= !in_range_c;
            addr_q    <= req_addr[AW-1:0];
            if (LATENCY == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              err_q     <= !in_range_c;
              load_q    <= !req_we && in_range_c;
            end else begin
              state    <= WAIT;
              wait_cnt <= LAT_W'(LATENCY - 1);
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            err_q     <= oor_q;
            load_q    <= !we_q && !oor_q;
          end else begin
            wait_cnt <= wait_cnt - LAT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            err_q     <= 1'b0;
            load_q    <= 1'b0;
            req_ready <= 1'b1;
            if (oor_q) begin
              if (err_count != '1) err_count <= err_count + CNT_W'(1);
            end else if (we_q) begin
              if (wr_count != '1) wr_count <= wr_count + CNT_W'(1);
            end else begin
              if (rd_count != '1) rd_count <= rd_count + CNT_W'(1);
            end
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
